bank_req_arbiter: RTL and testbench

- Drain side of the per-bank request buffers: watches the head of each read FIFO (ARR_NUM_RD) and write FIFO (ARR_NUM_WR) that the selector fills, and issues one pop per cycle.
- Chooses between read and write mode using write-pressure watermarks, then prefers row hits against the currently open row.
- Hands one request per cycle to the bank command generator through a registered valid/ready output stage.

---
 rtl/bank_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_bank_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_req_arbiter.sv
// Drain-side arbiter for the per-bank read/write request FIFOs: picks read or write mode, then one head per cycle.
// Optional macro ARB_TURNAROUND_EN inserts a TURN state of TURN_CYCLES idle cycles on every mode switch.
module bank_req_arbiter #(
    parameter int RA_BITS     = 16,
    parameter int INDEX_BITS  = 7,
    parameter int DATA_BITS   = 16,
    parameter int ARR_NUM_RD  = 4,
    parameter int ARR_NUM_WR  = 3,
    parameter int WR_HIGH_WM  = 2,
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [ARR_NUM_RD-1:0]                       rd_valid,
    input  logic [ARR_NUM_RD*(RA_BITS+INDEX_BITS)-1:0]  rd_data,
    output logic [ARR_NUM_RD-1:0]                       rd_pop,
    input  logic [ARR_NUM_WR-1:0]                       wr_valid,
    input  logic [ARR_NUM_WR-1:0]                       wr_mid,
    input  logic [ARR_NUM_WR*(RA_BITS+DATA_BITS+INDEX_BITS)-1:0] wr_data,
    output logic [ARR_NUM_WR-1:0]                       wr_pop,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_type,
    output logic [RA_BITS-1:0]                          out_row,
    output logic [DATA_BITS-1:0]                        out_data,
    output logic [INDEX_BITS-1:0]                       out_index,
    output logic [RA_BITS-1:0]                          open_row,
    output logic                                        open_vld
);

    localparam int W_RD  = RA_BITS + INDEX_BITS;
    localparam int W_WR  = RA_BITS + DATA_BITS + INDEX_BITS;
    localparam int N_MAX = (ARR_NUM_RD > ARR_NUM_WR) ? ARR_NUM_RD : ARR_NUM_WR;
    localparam int PW    = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int BW    = $clog2(MAX_BURST + 1);

    localparam logic [1:0] MODE_RD   = 2'd0;
    localparam logic [1:0] MODE_WR   = 2'd1;
`ifdef ARB_TURNAROUND_EN
    localparam logic [1:0] MODE_TURN = 2'd2;
    localparam int         TW        = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;
`endif

    logic [1:0]            mode_q, mode_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         lock_q, lock_d;
    logic                  lock_vld_q, lock_vld_d;
    logic [RA_BITS-1:0]    open_row_q, open_row_d;
    logic                  open_vld_q, open_vld_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_type_q, out_type_d;
    logic [RA_BITS-1:0]    out_row_q, out_row_d;
    logic [DATA_BITS-1:0]  out_data_q, out_data_d;
    logic [INDEX_BITS-1:0] out_index_q, out_index_d;
`ifdef ARB_TURNAROUND_EN
    logic [TW-1:0]         turn_cnt_q, turn_cnt_d;
    logic [1:0]            turn_tgt_q, turn_tgt_d;
`endif

    // Unpacked views of the FIFO heads.
    logic [RA_BITS-1:0]    rd_row [ARR_NUM_RD];
    logic [INDEX_BITS-1:0] rd_idx [ARR_NUM_RD];
    logic [RA_BITS-1:0]    wr_row [ARR_NUM_WR];
    logic [DATA_BITS-1:0]  wr_dat [ARR_NUM_WR];
    logic [INDEX_BITS-1:0] wr_idx [ARR_NUM_WR];

    for (genvar g = 0; g < ARR_NUM_RD; g++) begin : g_rd_head
        assign rd_row[g] = rd_data[g*W_RD +: RA_BITS];
        assign rd_idx[g] = rd_data[g*W_RD + RA_BITS +: INDEX_BITS];
    end

    for (genvar g = 0; g < ARR_NUM_WR; g++) begin : g_wr_head
        assign wr_row[g] = wr_data[g*W_WR +: RA_BITS];
        assign wr_dat[g] = wr_data[g*W_WR + RA_BITS +: DATA_BITS];
        assign wr_idx[g] = wr_data[g*W_WR + RA_BITS + DATA_BITS +: INDEX_BITS];
    end

    logic                  is_rd, is_wr;
    logic [N_MAX-1:0]      cand_valid;
    logic [RA_BITS-1:0]    cand_row [N_MAX];
    logic [DATA_BITS-1:0]  cand_dat [N_MAX];
    logic [INDEX_BITS-1:0] cand_idx [N_MAX];
    int                    cand_n;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_rd      = (mode_q == MODE_RD);
        is_wr      = (mode_q == MODE_WR);
        cand_valid = '0;
        cand_n     = is_wr ? ARR_NUM_WR : ARR_NUM_RD;
        for (int i = 0; i < N_MAX; i++) begin
            cand_row[i] = '0;
            cand_dat[i] = '0;
            cand_idx[i] = '0;
        end
        if (is_rd) begin
            for (int i = 0; i < ARR_NUM_RD; i++) begin
                cand_valid[i] = rd_valid[i];
                cand_row[i]   = rd_row[i];
                cand_idx[i]   = rd_idx[i];
            end
        end else if (is_wr) begin
            for (int i = 0; i < ARR_NUM_WR; i++) begin
                cand_valid[i] = wr_valid[i];
                cand_row[i]   = wr_row[i];
                cand_dat[i]   = wr_dat[i];
                cand_idx[i]   = wr_idx[i];
            end
        end
    end

    logic          burst_full;
    logic          sel_found;
    logic [PW-1:0] sel_idx;

    always_comb begin : p_select
        int j;
        j          = 0;
        burst_full = (burst_cnt_q >= BW'(MAX_BURST));
        sel_found  = 1'b0;
        sel_idx    = '0;
        if (lock_vld_q && cand_valid[lock_q] && !burst_full) begin
            sel_found = 1'b1;
            sel_idx   = lock_q;
        end
        // A capped lock must not win again through a row hit, or the cap never releases.
        if (!sel_found && open_vld_q) begin
            for (int i = N_MAX - 1; i >= 0; i--) begin
                if (cand_valid[i] && cand_row[i] == open_row_q &&
                    !(burst_full && lock_vld_q && lock_q == PW'(i))) begin
                    sel_found = 1'b1;
                    sel_idx   = PW'(i);
                end
            end
        end
        if (!sel_found) begin
            for (int k = N_MAX; k >= 1; k--) begin
                if (k <= cand_n) begin
                    j = int'(rr_ptr_q) + k;
                    if (j >= cand_n) j = j - cand_n;
                    if (cand_valid[j]) begin
                        sel_found = 1'b1;
                        sel_idx   = PW'(j);
                    end
                end
            end
        end
    end

    int   wr_cnt;
    logic to_wr, to_rd, do_switch, slot_free, do_pop;

    always_comb begin
        wr_cnt = 0;
        for (int i = 0; i < ARR_NUM_WR; i++) wr_cnt = wr_cnt + int'(wr_valid[i]);
        to_wr = (wr_cnt >= WR_HIGH_WM) || (|wr_mid) || (!(|rd_valid) && (|wr_valid));
        to_rd = (|rd_valid) &&
                (!(|wr_valid) || (!(|wr_mid) && wr_cnt < WR_HIGH_WM && burst_full));
        do_switch = (is_rd && to_wr) || (is_wr && to_rd);
        slot_free = !out_valid_q || out_ready;
        do_pop    = rst_n && slot_free && !do_switch && sel_found && (is_rd || is_wr);
    end

    always_comb begin
        rd_pop = '0;
        wr_pop = '0;
        for (int i = 0; i < ARR_NUM_RD; i++) rd_pop[i] = do_pop && is_rd && (sel_idx == PW'(i));
        for (int i = 0; i < ARR_NUM_WR; i++) wr_pop[i] = do_pop && is_wr && (sel_idx == PW'(i));
    end

    always_comb begin
        mode_d      = mode_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_vld_d  = lock_vld_q;
        open_row_d  = open_row_q;
        open_vld_d  = open_vld_q;
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_row_d   = out_row_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
`ifdef ARB_TURNAROUND_EN
        turn_cnt_d  = turn_cnt_q;
        turn_tgt_d  = turn_tgt_q;
        if (mode_q == MODE_TURN) begin
            if (turn_cnt_q <= TW'(1)) mode_d = turn_tgt_q;
            else                      turn_cnt_d = turn_cnt_q - TW'(1);
        end
`endif
        if (do_switch) begin
            lock_vld_d  = 1'b0;
            burst_cnt_d = '0;
            rr_ptr_d    = '0;
`ifdef ARB_TURNAROUND_EN
            if (TURN_CYCLES > 0) begin
                mode_d     = MODE_TURN;
                turn_cnt_d = TW'(TURN_CYCLES);
                turn_tgt_d = is_rd ? MODE_WR : MODE_RD;
            end else begin
                mode_d = is_rd ? MODE_WR : MODE_RD;
            end
`else
            mode_d = is_rd ? MODE_WR : MODE_RD;
`endif
        end else if (do_pop) begin
            if (lock_vld_q && lock_q == sel_idx)
                burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + BW'(1);
            else
                burst_cnt_d = BW'(1);
            lock_d     = sel_idx;
            lock_vld_d = 1'b1;
            rr_ptr_d   = sel_idx;
            open_row_d = cand_row[sel_idx];
            open_vld_d = 1'b1;
        end
        if (slot_free) begin
            out_valid_d = do_pop;
            if (do_pop) begin
                out_type_d  = is_rd;
                out_row_d   = cand_row[sel_idx];
                out_data_d  = is_rd ? '0 : cand_dat[sel_idx];
                out_index_d = cand_idx[sel_idx];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_RD;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= '0;
            lock_vld_q  <= 1'b0;
            open_row_q  <= '0;
            open_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_type_q  <= 1'b0;
            out_row_q   <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
`ifdef ARB_TURNAROUND_EN
            turn_cnt_q  <= '0;
            turn_tgt_q  <= MODE_RD;
`endif
        end else begin
            mode_q      <= mode_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_vld_q  <= lock_vld_d;
            open_row_q  <= open_row_d;
            open_vld_q  <= open_vld_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
`ifdef ARB_TURNAROUND_EN
            turn_cnt_q  <= turn_cnt_d;
            turn_tgt_q  <= turn_tgt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_row   = out_row_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign open_row  = open_row_q;
    assign open_vld  = open_vld_q;

endmodule

// File: tb/tb_bank_req_arbiter.sv
// Directed bench for bank_req_arbiter: row hits, burst cap, write pressure, backpressure and reset.
module tb_bank_req_arbiter;

    localparam int RA  = 16;
    localparam int IX  = 7;
    localparam int DB  = 16;
    localparam int NRD = 4;
    localparam int NWR = 3;
    localparam int WRD = RA + IX;
    localparam int WWR = RA + DB + IX;
`ifdef ARB_TURNAROUND_EN
    localparam int IDLE = 3;
`else
    localparam int IDLE = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD-1:0]    rd_valid;
    logic [NRD*WRD-1:0] rd_data;
    logic [NRD-1:0]    rd_pop;
    logic [NWR-1:0]    wr_valid;
    logic [NWR-1:0]    wr_mid;
    logic [NWR*WWR-1:0] wr_data;
    logic [NWR-1:0]    wr_pop;
    logic              out_valid;
    logic              out_ready;
    logic              out_type;
    logic [RA-1:0]     out_row;
    logic [DB-1:0]     out_data;
    logic [IX-1:0]     out_index;
    logic [RA-1:0]     open_row;
    logic              open_vld;

    int checks = 0;
    int errors = 0;

    bank_req_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_pop    (rd_pop),
        .wr_valid  (wr_valid),
        .wr_mid    (wr_mid),
        .wr_data   (wr_data),
        .wr_pop    (wr_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_row   (out_row),
        .out_data  (out_data),
        .out_index (out_index),
        .open_row  (open_row),
        .open_vld  (open_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int g, input logic [RA-1:0] row, input logic [IX-1:0] idx);
        rd_data[g*WRD +: WRD] = {idx, row};
    endtask

    task automatic set_wr(input int g, input logic [RA-1:0] row, input logic [DB-1:0] dat,
                          input logic [IX-1:0] idx);
        wr_data[g*WWR +: WWR] = {idx, dat, row};
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        rd_valid  = '0;
        wr_valid  = '0;
        wr_mid    = '0;
        rd_data   = '0;
        wr_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, with a read head already valid: no pop may leak out.
        rst_n     = 1'b0;
        wr_valid  = '0;
        wr_mid    = '0;
        wr_data   = '0;
        rd_data   = '0;
        out_ready = 1'b1;
        rd_valid  = 4'b0001;
        set_rd(0, 16'h1234, 7'h05);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rd_pop", rd_pop, 4'b0000);
        check("rst_open_vld", open_vld, 1'b0);
        check("rst_out_row", out_row, 16'h0000);
        tick();
        tick();

        // Same-row reads pop every cycle.
        rst_n = 1'b1;
        #1;
        check("same_pop0", rd_pop, 4'b0001);
        check("same_wr_pop0", wr_pop, 3'b000);
        tick();
        check("same_valid", out_valid, 1'b1);
        check("same_type", out_type, 1'b1);
        check("same_row", out_row, 16'h1234);
        check("same_index", out_index, 7'h05);
        check("same_data", out_data, 16'h0000);
        check("same_open_row", open_row, 16'h1234);
        check("same_open_vld", open_vld, 1'b1);
        #1;
        check("same_pop1", rd_pop, 4'b0001);
        tick();
        check("same_valid2", out_valid, 1'b1);

        // Both modes empty: no pop, open row retained.
        rd_valid = '0;
        #1;
        check("empty_rd_pop", rd_pop, 4'b0000);
        check("empty_wr_pop", wr_pop, 3'b000);
        tick();
        check("empty_out_valid", out_valid, 1'b0);
        check("empty_open_row", open_row, 16'h1234);
        check("empty_open_vld", open_vld, 1'b1);

        // Row-hit preference over round-robin.
        apply_reset();
        rd_valid = 4'b0001;
        set_rd(0, 16'h00AA, 7'h01);
        #1;
        check("hit_seed_pop", rd_pop, 4'b0001);
        tick();
        rd_valid = 4'b1010;
        set_rd(1, 16'h0055, 7'h02);
        set_rd(3, 16'h00AA, 7'h03);
        #1;
        check("hit_pop_fifo3", rd_pop, 4'b1000);
        tick();
        check("hit_row", out_row, 16'h00AA);
        check("hit_index", out_index, 7'h03);
        rd_valid = 4'b0010;
        #1;
        check("hit_then_fifo1", rd_pop, 4'b0010);
        tick();
        check("hit_row2", out_row, 16'h0055);
        check("hit_index2", out_index, 7'h02);

        // Burst cap: eight pops of FIFO0, then FIFO2.
        apply_reset();
        set_rd(0, 16'h0100, 7'h10);
        set_rd(2, 16'h0200, 7'h20);
        for (int i = 0; i < 8; i++) begin
            rd_valid = (i == 0) ? 4'b0001 : 4'b0101;
            #1;
            check("burst_fifo0", rd_pop, 4'b0001);
            tick();
        end
        #1;
        check("burst_switch_fifo2", rd_pop, 4'b0100);
        tick();
        check("burst_row", out_row, 16'h0200);
        check("burst_index", out_index, 7'h20);
        #1;
        check("burst_fifo2_lock", rd_pop, 4'b0100);
        tick();

        // Write pressure forces write mode after the idle switch cycle(s).
        apply_reset();
        rd_valid = 4'b0001;
        set_rd(0, 16'h0111, 7'h0B);
        wr_valid = 3'b011;
        set_wr(0, 16'h0300, 16'hBEEF, 7'h11);
        set_wr(1, 16'h0400, 16'hCAFE, 7'h12);
        for (int i = 0; i < IDLE; i++) begin
            #1;
            check("wm_idle_rd_pop", rd_pop, 4'b0000);
            check("wm_idle_wr_pop", wr_pop, 3'b000);
            tick();
        end
        #1;
        check("wm_wr_pop", wr_pop, 3'b010);
        check("wm_rd_pop", rd_pop, 4'b0000);
        tick();
        check("wm_out_valid", out_valid, 1'b1);
        check("wm_out_type", out_type, 1'b0);
        check("wm_out_row", out_row, 16'h0400);
        check("wm_out_data", out_data, 16'hCAFE);
        check("wm_out_index", out_index, 7'h12);

        // Writes drained: switch back to read mode.
        wr_valid = '0;
        for (int i = 0; i < IDLE; i++) begin
            #1;
            check("back_idle_rd_pop", rd_pop, 4'b0000);
            check("back_idle_wr_pop", wr_pop, 3'b000);
            tick();
        end
        #1;
        check("back_rd_pop", rd_pop, 4'b0001);
        tick();
        check("back_out_type", out_type, 1'b1);
        check("back_out_row", out_row, 16'h0111);

        // Backpressure: one pop, then output held until ready returns.
        apply_reset();
        out_ready = 1'b0;
        rd_valid  = 4'b0001;
        set_rd(0, 16'h0777, 7'h07);
        #1;
        check("bp_first_pop", rd_pop, 4'b0001);
        tick();
        set_rd(0, 16'h0778, 7'h08);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_row", out_row, 16'h0777);
            check("bp_hold_index", out_index, 7'h07);
            #1;
            check("bp_no_pop", rd_pop, 4'b0000);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_pop", rd_pop, 4'b0001);
        tick();
        check("bp_next_row", out_row, 16'h0778);
        check("bp_next_index", out_index, 7'h08);

        // Reset in write mode with a request in the output slot.
        apply_reset();
        wr_valid = 3'b001;
        set_wr(0, 16'h0500, 16'h1357, 7'h15);
        for (int i = 0; i < IDLE; i++) begin
            #1;
            check("rm_idle_wr_pop", wr_pop, 3'b000);
            tick();
        end
        #1;
        check("rm_wr_pop", wr_pop, 3'b001);
        tick();
        check("rm_pre_valid", out_valid, 1'b1);
        check("rm_pre_type", out_type, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", out_valid, 1'b0);
        check("rm_open_vld", open_vld, 1'b0);
        check("rm_open_row", open_row, 16'h0000);
        check("rm_out_data", out_data, 16'h0000);
        check("rm_wr_pop", wr_pop, 3'b000);
        check("rm_rd_pop", rd_pop, 4'b0000);
        tick();
        rst_n    = 1'b1;
        wr_valid = '0;
        rd_valid = 4'b0001;
        set_rd(0, 16'h0888, 7'h09);
        #1;
        check("rm_mode_rd_pop", rd_pop, 4'b0001);
        tick();
        check("rm_after_type", out_type, 1'b1);
        check("rm_after_row", out_row, 16'h0888);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
